// File: rtl/mux8_pkg.sv
// Shared definitions for the register bank / scan sequencer that feeds the
// 16-bit 8:1 multiplexer.
//   DEPTH      : number of bank entries (mux inputs)
//   AW         : width of the mux select / write index
//   DEF_WIDTH  : default data width
//   scan_state_t : sequencer FSM states
//   scan_map() : step counter -> mux select (binary or Gray order)
package mux8_pkg;

  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Gray order visits 000,001,011,010,110,111,101,100.
  function automatic logic [AW-1:0] scan_map(input logic [AW-1:0] step,
                                             input logic          gray);
    logic [AW-1:0] m;
    if (gray) begin
      m = step ^ {1'b0, step[AW-1:1]};
    end else begin
      m = step;
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_bank8x16_scan_if.sv
// Bus bundle between the register bank / scan sequencer and its environment.
//   we, waddr, wdata      : bank write port
//   start, gray_mode      : scan request and order select
//   addr, addr_valid      : mux select offered to the consumer
//   addr_ready            : consumer accepts the current select
//   busy, done            : scan status
// slave  = the design side, master = the driving environment.
interface reg_bank8x16_scan_if
  import mux8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             start;
  logic             gray_mode;
  logic [AW-1:0]    addr;
  logic             addr_valid;
  logic             addr_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  we, waddr, wdata, start, gray_mode, addr_ready,
    output addr, addr_valid, busy, done
  );

  modport master (
    output we, waddr, wdata, start, gray_mode, addr_ready,
    input  addr, addr_valid, busy, done
  );

endinterface

// File: rtl/scan_seq8.sv
// Scan sequencer: walks the mux select through all eight entries once per
// start request, offering each select with a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : scan request, only looked at in IDLE
//   gray_mode   : order select, captured together with start
//   addr_ready  : consumer accepts addr this cycle
//   addr        : registered mux select
//   addr_valid  : addr is offered
//   busy        : scan in progress
//   done        : one-cycle pulse after the eighth accepted step
module scan_seq8
  import mux8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          gray_mode,
  input  logic          addr_ready,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          busy,
  output logic          done
);

  scan_state_t   state_r, state_s;
  logic [AW-1:0] step_r, step_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          valid_r, valid_s;
  logic          done_r, done_s;
  logic          gray_r, gray_s;
  logic          busy_r, busy_s;
  logic [AW-1:0] step_inc_s;

  assign step_inc_s = step_r + 3'd1;

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      step_r  <= 3'd0;
      addr_r  <= 3'd0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      gray_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      addr_r  <= addr_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      gray_r  <= gray_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    addr_s  = addr_r;
    valid_s = valid_r;
    done_s  = 1'b0;
    gray_s  = gray_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          step_s  = 3'd0;
          addr_s  = scan_map(3'd0, gray_mode);
          gray_s  = gray_mode;
          valid_s = 1'b1;
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (valid_r && addr_ready) begin
          if (step_r == 3'd7) begin
            // addr keeps the last select; only valid drops.
            valid_s = 1'b0;
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            step_s = step_inc_s;
            addr_s = scan_map(step_inc_s, gray_r);
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase

    // busy is registered, so derive it from the state being entered.
    busy_s = (state_s == SCAN);
  end

  assign addr       = addr_r;
  assign addr_valid = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: rtl/reg_bank8x16_scan.sv
// Eight-entry register bank feeding the 16-bit 8:1 multiplexer, plus the
// scan sequencer that drives the mux select.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : write port, scan control and select handshake (slave side)
//   D0..D7     : bank contents, wired straight to the mux data inputs
module reg_bank8x16_scan
  import mux8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_bank8x16_scan_if.slave bus,
  output logic [WIDTH-1:0]   D0,
  output logic [WIDTH-1:0]   D1,
  output logic [WIDTH-1:0]   D2,
  output logic [WIDTH-1:0]   D3,
  output logic [WIDTH-1:0]   D4,
  output logic [WIDTH-1:0]   D5,
  output logic [WIDTH-1:0]   D6,
  output logic [WIDTH-1:0]   D7
);

  logic [WIDTH-1:0] entry_r [DEPTH];

  // Bank write; accepted in every sequencer state, including mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else if (bus.we) begin
      entry_r[bus.waddr] <= bus.wdata;
    end
  end

  assign D0 = entry_r[0];
  assign D1 = entry_r[1];
  assign D2 = entry_r[2];
  assign D3 = entry_r[3];
  assign D4 = entry_r[4];
  assign D5 = entry_r[5];
  assign D6 = entry_r[6];
  assign D7 = entry_r[7];

  scan_seq8 u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bus.start),
    .gray_mode  (bus.gray_mode),
    .addr_ready (bus.addr_ready),
    .addr       (bus.addr),
    .addr_valid (bus.addr_valid),
    .busy       (bus.busy),
    .done       (bus.done)
  );

endmodule

// File: tb/tb_reg_bank8x16_scan.sv
// Self-checking bench for reg_bank8x16_scan: table-driven bank load and
// a scoreboard of expected mux selects consumed on every handshake.
module tb_reg_bank8x16_scan;

  logic clk;
  logic rst_n;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [15:0] dout [8];
  logic [15:0] mux_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [8];
  logic [2:0]  exp_q [$];
  logic [2:0]  bin_ord  [8];
  logic [2:0]  gray_ord [8];

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] val;
  } wr_vec_t;
  wr_vec_t wv [8];

  reg_bank8x16_scan_if #(.WIDTH(16)) bus ();

  reg_bank8x16_scan #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .D0    (d0),
    .D1    (d1),
    .D2    (d2),
    .D3    (d3),
    .D4    (d4),
    .D5    (d5),
    .D6    (d6),
    .D7    (d7)
  );

  assign dout[0] = d0;
  assign dout[1] = d1;
  assign dout[2] = d2;
  assign dout[3] = d3;
  assign dout[4] = d4;
  assign dout[5] = d5;
  assign dout[6] = d6;
  assign dout[7] = d7;
  // Behaviour of the downstream Mul16b8x1.
  assign mux_out = dout[bus.addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.addr_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    for (int i = 0; i < 8; i++) check({tag, "_D"}, 32'(dout[i]), 32'd0);
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = idx; bus.wdata = val;
    check("wr_before_edge", 32'(dout[idx]), 32'(mem[idx]));
    @(negedge clk);
    bus.we = 1'b0;
    mem[idx] = val;
    check("wr_after_edge", 32'(dout[idx]), 32'(val));
  endtask

  // One scan. Negative step arguments disable the optional event.
  task automatic run_scan(input logic g, input int stall_step, input int stall_n,
                          input int pulse_step, input int wr_step, input logic [15:0] wr_val,
                          input int abort_step, input int exp_edges);
    int hs, stalls, edges;
    logic seen_done, do_wr;
    logic [2:0] ea, last_a;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(g ? gray_ord[i] : bin_ord[i]);
    last_a = 3'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.gray_mode = g; bus.addr_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.gray_mode = ~g;  // late change must not affect order
    check("start_valid", 32'(bus.addr_valid), 32'd1);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_addr", 32'(bus.addr), 32'd0);
    hs = 0; stalls = 0; edges = 0; seen_done = 1'b0;
    while (!seen_done && edges < 40) begin
      if (hs == abort_step) begin
        bus.start = 1'b0; bus.addr_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        exp_q.delete();
        return;
      end
      bus.start = (hs == pulse_step);
      do_wr = (hs == wr_step);
      if (hs == stall_step && stalls < stall_n) begin
        bus.addr_ready = 1'b0;
        stalls++;
        check("stall_addr", 32'(bus.addr), 32'(exp_q[0]));
        check("stall_valid", 32'(bus.addr_valid), 32'd1);
      end else begin
        bus.addr_ready = 1'b1;
        check("hs_valid", 32'(bus.addr_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check("hs_extra_step", 32'd1, 32'd0);
        end else begin
          ea = exp_q.pop_front();
          last_a = ea;
          check("hs_addr", 32'(bus.addr), 32'(ea));
          check("hs_data", 32'(mux_out), 32'(mem[ea]));
        end
        hs++;
      end
      if (do_wr) begin
        bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = wr_val;
      end else begin
        bus.we = 1'b0;
      end
      @(negedge clk);
      if (do_wr) mem[5] = wr_val;
      bus.we = 1'b0; bus.start = 1'b0;
      edges++;
      if (bus.done) seen_done = 1'b1;
    end
    bus.addr_ready = 1'b0;
    check("edges_to_done", 32'(edges), 32'(exp_edges));
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_valid", 32'(bus.addr_valid), 32'd0);
    check("done_addr_hold", 32'(bus.addr), 32'(last_a));
    check("all_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bin_ord  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    gray_ord = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    wv[0] = '{3'd0, 16'ha1b2}; wv[1] = '{3'd1, 16'ha3b4};
    wv[2] = '{3'd2, 16'hc3d4}; wv[3] = '{3'd3, 16'hc5d6};
    wv[4] = '{3'd4, 16'he5f6}; wv[5] = '{3'd5, 16'he7f8};
    wv[6] = '{3'd6, 16'h0718}; wv[7] = '{3'd7, 16'h0910};
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

    bus.we = 1'b0; bus.waddr = 3'd0; bus.wdata = 16'h0000;
    bus.start = 1'b0; bus.gray_mode = 1'b0; bus.addr_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Bank load from the vector table.
    for (int i = 0; i < 8; i++) do_write(wv[i].idx, wv[i].val);
    for (int i = 0; i < 8; i++) check("bank_readback", 32'(dout[wv[i].idx]), 32'(wv[i].val));

    // Binary and Gray scans with the consumer always ready.
    run_scan(1'b0, -1, 0, -1, -1, 16'h0000, -1, 8);
    run_scan(1'b1, -1, 0, -1, -1, 16'h0000, -1, 8);
    // Backpressure: three stalled cycles at step 2 (addr 011).
    run_scan(1'b1, 2, 3, -1, -1, 16'h0000, -1, 11);
    // start pulsed mid-scan is ignored: one done, then idle stays idle.
    run_scan(1'b0, -1, 0, 3, -1, 16'h0000, -1, 8);
    repeat (3) begin
      @(negedge clk);
      check("ignored_start_done", 32'(bus.done), 32'd0);
      check("ignored_start_busy", 32'(bus.busy), 32'd0);
    end
    // Write entry 5 during the scan, before step 5 is offered.
    run_scan(1'b0, -1, 0, -1, 2, 16'h5a5a, -1, 8);
    check("mid_scan_write", 32'(d5), 32'h5a5a);
    // Reset at step 4 aborts the scan without a done pulse.
    run_scan(1'b1, -1, 0, -1, -1, 16'h0000, 4, 8);
    // Sequencer recovers after the abort.
    run_scan(1'b0, -1, 0, -1, -1, 16'h0000, -1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
